max_128b_seq: RTL and testbench
===============================

MAX_128B_SEQ -- requirements
Module: max_128b_seq

Interface
REQ-001 Parameter WIDTH, default 128: operand and result width in bits; all operands are unsigned.
REQ-002 Parameter NUM_IN, default 4: operands per group; the index width is clog2(NUM_IN), which is 2.
REQ-003 Clocking: one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 clear  input  1  synchronous abort of the current group.
REQ-007 in_data  input  WIDTH  operand.
REQ-008 in_valid  input  1  in_data is valid this cycle.
REQ-009 in_ready  output  1  block accepts an operand this cycle.
REQ-010 out0  output  WIDTH  maximum of the completed group.
REQ-011 out1  output  2  position (0..3) of the maximum within the group.
REQ-012 out_valid  output  1  out0/out1 hold a completed result.
REQ-013 out_ready  input  1  downstream consumes the result.

Function
REQ-014 States: COLLECT and HOLD; in_ready SHALL be decoded combinationally as (state==COLLECT), with no dependence on in_valid.
REQ-015 An operand is accepted on a rising edge where in_valid and in_ready are both 1; a 2-bit counter cnt holds the position of the next operand.
REQ-016 Accepting with cnt==0: running max SHALL load in_data unconditionally and running index SHALL load 0.
REQ-017 Accepting with cnt>0: if in_data > running max (unsigned, strictly greater), the block SHALL load max<=in_data and idx<=cnt; otherwise max and idx SHALL be unchanged.
REQ-018 Ties SHALL keep the earliest position; 0 is a valid maximum.
REQ-019 Accepting with cnt==NUM_IN-1: the transition SHALL be COLLECT->HOLD, and out_valid SHALL be 1 in the next cycle, one cycle after the 4th accept.
REQ-020 In HOLD: in_ready=0, out_valid=1, and out0/out1 SHALL be stable until the handshake.
REQ-021 In HOLD, out_valid&out_ready on a rising edge SHALL return the block to COLLECT with cnt=0; in_ready is 1 in the following cycle (no same-cycle bypass).
REQ-022 Peak throughput SHALL be one group per NUM_IN+1 cycles.
REQ-023 out0/out1 are the running max/idx registers; their value during COLLECT is don't-care to downstream, but SHALL be deterministic: the last result, or partial state.
REQ-024 clear=1 in COLLECT: cnt<=0 and any in_valid that cycle SHALL be discarded.
REQ-025 clear=1 in HOLD: the block SHALL drop the result and go to COLLECT with cnt=0 and out_valid=0.
REQ-026 clear SHALL take priority over every handshake in the same cycle.
REQ-027 in_valid deasserted mid-group: the block SHALL wait indefinitely with partial state preserved; there is no timeout.

Reset
REQ-028 On rst_n=0: state=COLLECT, cnt=0, out0=0, out1=0, out_valid=0; in_ready reads 1 during and after reset.
REQ-029 Reset mid-group or in HOLD SHALL discard all partial or pending results; the first accept after release is position 0.

Structure
REQ-030 A shared package max_pkg SHALL hold the constants WIDTH=128, NUM_IN=4 and IDX_W=2, plus the state enum type (COLLECT, HOLD).
REQ-031 The unsigned greater-than compare SHALL be one sub-module, max_128b_cmp (a,b -> a_gt_b), instantiated once.

Verification
REQ-032 Reset check: hold rst_n=0 for 3 cycles, then release -> out_valid=0, out0=0, out1=0, in_ready=1.
REQ-033 Basic group: stream 5, 9, 2, 7 back-to-back with out_ready=1 -> out_valid for exactly 1 cycle, out0=9, out1=1; in_ready=0 for exactly 1 cycle.
REQ-034 Tie/extreme group: stream 2^128-1, 3, 2^128-1, 0 -> out0=2^128-1, out1=0; a group of all-zero operands -> out0=0, out1=0.
REQ-035 Backpressure: group 1,2,3,4 with out_ready=0 for 10 cycles -> out0=4, out1=3 held stable, in_ready=0 throughout; out_ready=1 -> out_valid drops next cycle.
REQ-036 Clear: accept 100, 200, then clear=1 together with in_valid carrying 300; then stream 1, 8, 8, 3 -> out0=8, out1=1, with no trace of 100/200/300.
REQ-037 Reset mid-operation: accept 2 operands, assert rst_n=0 asynchronously between clock edges -> out_valid=0 immediately; the next group 4, 3, 2, 1 yields out0=4, out1=0.

Source files
------------

// File: rtl/max_pkg.sv
// ---------------------------------------------------------------------------
// max_pkg
// Shared constants and types for the sequential group-maximum block.
//   WIDTH   : operand / result width in bits (operands are unsigned)
//   NUM_IN  : operands per group
//   IDX_W   : width of the position index, clog2(NUM_IN)
//   state_t : control states (COLLECT while accepting operands, HOLD while
//             presenting a finished result)
// ---------------------------------------------------------------------------
package max_pkg;

    localparam int WIDTH  = 128;
    localparam int NUM_IN = 4;
    localparam int IDX_W  = 2;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

endpackage : max_pkg

// File: rtl/max_128b_cmp.sv
// ---------------------------------------------------------------------------
// max_128b_cmp
// Unsigned strict greater-than comparator.
//   a      : input  [WIDTH-1:0]  candidate operand
//   b      : input  [WIDTH-1:0]  current running maximum
//   a_gt_b : output              1 when a > b (unsigned); ties give 0
// ---------------------------------------------------------------------------
module max_128b_cmp #(
    parameter int WIDTH = max_pkg::WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             a_gt_b
);

    // Strictly greater: an equal later operand must not displace the
    // earlier position.
    assign a_gt_b = (a > b);

endmodule : max_128b_cmp

// File: rtl/max_128b_seq.sv
// ---------------------------------------------------------------------------
// max_128b_seq
// Accepts NUM_IN unsigned operands one per handshake, tracks the running
// maximum and its position, then holds the result until downstream takes it.
//   clk       : input               rising-edge clock
//   rst_n     : input               asynchronous active-low reset
//   clear     : input               synchronous abort of the current group
//   in_data   : input  [WIDTH-1:0]  operand
//   in_valid  : input               in_data valid this cycle
//   in_ready  : output              block accepts an operand (state COLLECT)
//   out0      : output [WIDTH-1:0]  maximum of the completed group
//   out1      : output [IDX_W-1:0]  position of that maximum in the group
//   out_valid : output              out0/out1 hold a completed result
//   out_ready : input               downstream consumes the result
// ---------------------------------------------------------------------------
module max_128b_seq #(
    parameter int WIDTH  = max_pkg::WIDTH,
    parameter int NUM_IN = max_pkg::NUM_IN
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clear,
    input  logic [WIDTH-1:0]          in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [WIDTH-1:0]          out0,
    output logic [$clog2(NUM_IN)-1:0] out1,
    output logic                      out_valid,
    input  logic                      out_ready
);

    import max_pkg::*;

    localparam int               CNT_W = $clog2(NUM_IN);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(NUM_IN - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_max;
    logic [CNT_W-1:0]   r_idx;
    logic               w_accept;
    logic               w_last;
    logic               w_gt;

    // Both handshake signals are pure state decodes; nothing on the input
    // side feeds through to in_ready.
    assign in_ready  = (r_state == COLLECT);
    assign out_valid = (r_state == HOLD);

    // clear wins over the input handshake: an operand offered in a clear
    // cycle is dropped.
    assign w_accept  = in_valid & in_ready & ~clear;
    assign w_last    = (r_cnt == LAST);

    assign out0 = r_max;
    assign out1 = r_idx;

    max_128b_cmp #(
        .WIDTH (WIDTH)
    ) u_cmp (
        .a      (in_data),
        .b      (r_max),
        .a_gt_b (w_gt)
    );

    // NOTE: every variable assigned in an always_comb gets a default first,
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        if (clear) begin
            w_state_nxt = COLLECT;
        end else begin
            case (r_state)
                COLLECT: if (w_accept && w_last) w_state_nxt = HOLD;
                HOLD:    if (out_ready)          w_state_nxt = COLLECT;
                default:                         w_state_nxt = COLLECT;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= COLLECT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Position counter; wraps to 0 on the last operand, which is also the
    // value required when HOLD is released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= w_last ? '0 : r_cnt + 1'b1;
        end
    end

    // Running max/index. The first operand of a group loads unconditionally,
    // so a stale value from the previous group never leaks in. These are left
    // untouched by clear; their content in COLLECT is a don't-care but stays
    // deterministic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_max <= '0;
            r_idx <= '0;
        end else if (w_accept && ((r_cnt == '0) || w_gt)) begin
            r_max <= in_data;
            r_idx <= r_cnt;
        end
    end

endmodule : max_128b_seq

// File: tb/tb_max_128b_seq.sv
// ---------------------------------------------------------------------------
// tb_max_128b_seq
// Self-checking bench for max_128b_seq. Expected (max, index) pairs are
// computed by a small reference model when a group is driven, queued, and
// compared when the DUT raises out_valid. Inputs change 1 time unit after the
// rising edge; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_max_128b_seq;

    import max_pkg::*;

    typedef logic [WIDTH-1:0] grp_t [NUM_IN];

    typedef struct {
        logic [WIDTH-1:0] mx;
        logic [IDX_W-1:0] ix;
    } exp_t;

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b0;
    logic             clear     = 1'b0;
    logic [WIDTH-1:0] in_data   = '0;
    logic             in_valid  = 1'b0;
    logic             out_ready = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] out0;
    logic [IDX_W-1:0] out1;
    logic             out_valid;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    max_128b_seq #(
        .WIDTH  (WIDTH),
        .NUM_IN (NUM_IN)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out0      (out0),
        .out1      (out1),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    task automatic check(input string tag, input logic [WIDTH-1:0] got,
                         input logic [WIDTH-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: earliest strictly-greater wins.
    function automatic exp_t model(input grp_t g);
        exp_t e;
        e.mx = g[0];
        e.ix = '0;
        for (int i = 1; i < NUM_IN; i++) begin
            if (g[i] > e.mx) begin
                e.mx = g[i];
                e.ix = IDX_W'(i);
            end
        end
        return e;
    endfunction

    // Entered and left at posedge+1; one operand accepted per call.
    task automatic drive_op(input logic [WIDTH-1:0] v);
        int n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) check("in_ready_timeout", 0, 1);
        in_valid = 1'b1;
        in_data  = v;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_group(input grp_t g, input bit push, input int gap);
        if (push) exp_q.push_back(model(g));
        for (int i = 0; i < NUM_IN; i++) begin
            drive_op(g[i]);
            if (i < NUM_IN - 1) begin
                repeat (gap) begin
                    @(posedge clk); #1;
                end
            end
        end
    endtask

    // Watches a bounded window of falling edges; scores the first result seen
    // against the queue head and counts valid / not-ready cycles.
    task automatic run_and_score(input string tag, input int cycles,
                                 output int n_valid, output int n_busy);
        exp_t e;
        bit   seen = 1'b0;
        n_valid = 0;
        n_busy  = 0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (out_valid) begin
                n_valid++;
                if (!seen) begin
                    seen = 1'b1;
                    if (exp_q.size() == 0) begin
                        check({tag, "_unexpected"}, 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check({tag, "_out0"}, out0, e.mx);
                        check({tag, "_out1"}, WIDTH'(out1), WIDTH'(e.ix));
                    end
                end
            end
            if (!in_ready) n_busy++;
        end
        if (!seen) check({tag, "_timeout"}, 0, 1);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        grp_t g;
        exp_t e;
        int   nv;
        int   nb;

        // Reset: held 3 cycles, in_ready visible during and after.
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready_during", in_ready, 1);
        rst_n = 1'b1;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out0", out0, 0);
        check("rst_out1", WIDTH'(out1), 0);
        check("rst_in_ready", in_ready, 1);
        @(posedge clk); #1;

        // Basic back-to-back group.
        out_ready = 1'b1;
        g = '{128'd5, 128'd9, 128'd2, 128'd7};
        send_group(g, 1'b1, 0);
        run_and_score("basic", 6, nv, nb);
        check("basic_valid_cycles", nv, 1);
        check("basic_busy_cycles", nb, 1);

        // Tie at the top of the range keeps the earliest position.
        g = '{'1, 128'd3, '1, 128'd0};
        send_group(g, 1'b1, 0);
        run_and_score("tie_ext", 6, nv, nb);

        g = '{128'd0, 128'd0, 128'd0, 128'd0};
        send_group(g, 1'b1, 0);
        run_and_score("zeros", 6, nv, nb);

        // Backpressure: result held stable for 10 cycles.
        out_ready = 1'b0;
        g = '{128'd1, 128'd2, 128'd3, 128'd4};
        send_group(g, 1'b1, 0);
        e = exp_q.pop_front();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("bp_out0", out0, e.mx);
            check("bp_out1", WIDTH'(out1), WIDTH'(e.ix));
            check("bp_valid", out_valid, 1);
            check("bp_in_ready", in_ready, 0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_valid_before_hs", out_valid, 1);
        @(negedge clk);
        check("bp_valid_after_hs", out_valid, 0);
        check("bp_in_ready_after_hs", in_ready, 1);
        @(posedge clk); #1;

        // Clear in COLLECT discards partial state and the concurrent operand.
        drive_op(128'd100);
        drive_op(128'd200);
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = 128'd300;
        @(posedge clk); #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        g = '{128'd1, 128'd8, 128'd8, 128'd3};
        send_group(g, 1'b1, 0);
        run_and_score("clear", 6, nv, nb);
        check("clear_valid_cycles", nv, 1);

        // Clear in HOLD drops the pending result.
        out_ready = 1'b0;
        g = '{128'd50, 128'd60, 128'd70, 128'd80};
        send_group(g, 1'b0, 0);
        @(negedge clk);
        check("clr_hold_valid", out_valid, 1);
        @(posedge clk); #1;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        @(negedge clk);
        check("clr_hold_dropped", out_valid, 0);
        check("clr_hold_in_ready", in_ready, 1);
        @(posedge clk); #1;

        // Idle gaps mid-group preserve partial state.
        out_ready = 1'b1;
        g = '{128'd10, 128'd30, 128'd30, 128'd20};
        send_group(g, 1'b1, 3);
        run_and_score("gap", 6, nv, nb);

        // Asynchronous reset mid-group.
        drive_op(128'd500);
        drive_op(128'd600);
        #3 rst_n = 1'b0;
        #1;
        check("arst_mid_valid", out_valid, 0);
        check("arst_mid_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Asynchronous reset while holding a result.
        out_ready = 1'b0;
        g = '{128'd9, 128'd9, 128'd9, 128'd9};
        send_group(g, 1'b0, 0);
        @(negedge clk);
        check("arst_hold_valid_pre", out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_hold_valid", out_valid, 0);
        check("arst_hold_out0", out0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        out_ready = 1'b1;
        g = '{128'd4, 128'd3, 128'd2, 128'd1};
        send_group(g, 1'b1, 0);
        run_and_score("post_rst", 6, nv, nb);

        // A few random groups; narrow values on odd groups to force ties.
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < NUM_IN; i++) begin
                if (k % 2 == 1) begin
                    g[i] = WIDTH'($urandom_range(0, 3));
                end else begin
                    g[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
                end
            end
            send_group(g, 1'b1, k % 3);
            run_and_score("rand", 6, nv, nb);
        end

        check("sb_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_max_128b_seq
